// File: rtl/mem_port_arbiter.sv
// Arbitrates the instruction-fetch and data ports onto one single-port memory.
// Optional macro STARVE_GUARD_EN bounds consecutive data grants while fetch waits.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              Pc_Write,
  output logic              If_Id_Write,
  output logic              Mem_Stall
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  state_t state;
  logic   starve_hit;
  logic   arb_point;
  logic   pick_data;
  logic   pick_fetch;

`ifdef STARVE_GUARD_EN
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;

  assign starve_hit = if_req && (starve_cnt == CNT_W'(STARVE_MAX));

  // Counts data grants made while fetch is waiting; never exceeds STARVE_MAX
  // because hitting the limit hands the next grant to fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!if_req) begin
      starve_cnt <= '0;
    end else if (arb_point && pick_fetch) begin
      starve_cnt <= '0;
    end else if (arb_point && pick_data) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  // Strict data priority; STARVE_MAX is referenced only to keep one interface.
  assign starve_hit = 1'b0 & (STARVE_MAX != 0);
`endif

  // NOTE: pure continuous assigns for the decode keep this path latch-free;
  // every grant decision is a complete function of the current inputs.
  assign arb_point  = (state == IDLE) || mem_ready;
  assign pick_data  = dm_req && !starve_hit;
  assign pick_fetch = if_req && !pick_data;

  assign Pc_Write    = if_valid;
  assign If_Id_Write = if_valid;
  assign Mem_Stall   = dm_req && !dm_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_valid  <= 1'b0;
      if_rdata  <= '0;
      dm_done   <= 1'b0;
      dm_rdata  <= '0;
    end else begin
      // NOTE: non-blocking throughout; the pulse defaults below are overridden
      // later in the same block and take effect together at the clock edge.
      if_valid <= 1'b0;
      dm_done  <= 1'b0;

      if (state == FETCH && mem_ready) begin
        if_valid <= 1'b1;
        if_rdata <= mem_rdata;
      end
      if (state == DATA && mem_ready) begin
        dm_done  <= 1'b1;
        dm_rdata <= mem_rdata;
      end

      // Completion re-arbitrates on the same edge so a waiting requester
      // follows without an idle cycle; mem_ready in IDLE is never looked at.
      if (arb_point) begin
        if (pick_data) begin
          state     <= DATA;
          mem_req   <= 1'b1;
          mem_we    <= dm_we;
          mem_addr  <= dm_addr;
          mem_wdata <= dm_wdata;
        end else if (pick_fetch) begin
          state    <= FETCH;
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= if_addr;
        end else begin
          state   <= IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic checked
// against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req = 1'b0;
  logic              dm_we = 1'b0;
  logic [ADDR_W-1:0] dm_addr = '0;
  logic [DATA_W-1:0] dm_wdata = '0;
  logic              dm_done;
  logic [DATA_W-1:0] dm_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              Pc_Write;
  logic              If_Id_Write;
  logic              Mem_Stall;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_done(dm_done), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .Pc_Write(Pc_Write), .If_Id_Write(If_Id_Write), .Mem_Stall(Mem_Stall)
  );

  // Transaction-level model: one outstanding access, who owns it, and the
  // run of data grants fetch has had to sit through.
  bit          m_busy;
  bit          m_is_data;
  bit          m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  bit          m_if_valid;
  bit          m_dm_done;
  logic [31:0] m_if_rdata;
  logic [31:0] m_dm_rdata;
  int          m_streak;

  function automatic bit fetch_wins(bit d, bit f, int streak);
`ifdef STARVE_GUARD_EN
    if (f && streak >= STARVE_MAX) return 1'b1;
`endif
    return f && !d;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_is_data = 0; m_we = 0; m_addr = '0; m_wdata = '0;
    m_if_valid = 0; m_dm_done = 0; m_if_rdata = '0; m_dm_rdata = '0;
    m_streak = 0;
  endtask

  task automatic model_edge(input bit d, input bit we, input logic [31:0] da,
                            input logic [31:0] dw, input bit f, input logic [31:0] fa,
                            input bit rdy, input logic [31:0] rd);
    bit finishing;
    bit got_f;
    bit got_d;
    finishing  = m_busy && rdy;
    m_if_valid = finishing && !m_is_data;
    m_dm_done  = finishing && m_is_data;
    if (m_if_valid) m_if_rdata = rd;
    if (m_dm_done)  m_dm_rdata = rd;
    got_f = 0;
    got_d = 0;
    if (!m_busy || rdy) begin
      if (fetch_wins(d, f, m_streak)) begin
        got_f = 1; m_busy = 1; m_is_data = 0; m_addr = fa; m_we = 0;
      end else if (d) begin
        got_d = 1; m_busy = 1; m_is_data = 1; m_addr = da; m_we = we; m_wdata = dw;
      end else begin
        m_busy = 0;
      end
    end
    if (!f)         m_streak = 0;
    else if (got_f) m_streak = 0;
    else if (got_d) m_streak = m_streak + 1;
  endtask

  // Drive one cycle of inputs on the falling edge, advance the model on the
  // rising edge, and leave the caller 1 ns after that edge to compare.
  task automatic step(input bit d, input bit we, input logic [31:0] da,
                      input logic [31:0] dw, input bit f, input logic [31:0] fa,
                      input bit rdy, input logic [31:0] rd);
    @(negedge clk);
    dm_req = d; dm_we = we; dm_addr = da; dm_wdata = dw;
    if_req = f; if_addr = fa; mem_ready = rdy; mem_rdata = rd;
    @(posedge clk);
    model_edge(d, we, da, dw, f, fa, rdy, rd);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    total++;
    if ({mem_req, mem_we, if_valid, dm_done, Pc_Write, If_Id_Write, Mem_Stall} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=0000000",
               {mem_req, mem_we, if_valid, dm_done, Pc_Write, If_Id_Write, Mem_Stall});
    end
    total++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      bad++;
      $display("FAIL reset_mem_bus addr=%h wdata=%h want=0", mem_addr, mem_wdata);
    end
    total++;
    if (if_rdata !== '0 || dm_rdata !== '0) begin
      bad++;
      $display("FAIL reset_rdata if=%h dm=%h want=0", if_rdata, dm_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_fetch();
    logic [31:0] rd;
    rd = 32'hA5A5_0001;
    step(0, 0, '0, '0, 1, 32'h100, 0, 32'h1);
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0) begin
      bad++;
      $display("FAIL fetch_grant req=%b addr=%h we=%b want 1/100/0", mem_req, mem_addr, mem_we);
    end
    step(0, 0, '0, '0, 1, 32'h100, 0, 32'h2);
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100 || if_valid !== 1'b0 || Pc_Write !== 1'b0) begin
      bad++;
      $display("FAIL fetch_wait req=%b addr=%h valid=%b pcw=%b want 1/100/0/0",
               mem_req, mem_addr, if_valid, Pc_Write);
    end
    step(0, 0, '0, '0, 0, 32'h100, 1, rd);
    total++;
    if (if_valid !== 1'b1 || if_rdata !== rd || Pc_Write !== 1'b1 || If_Id_Write !== 1'b1) begin
      bad++;
      $display("FAIL fetch_done valid=%b rdata=%h pcw=%b ifw=%b want 1/%h/1/1",
               if_valid, if_rdata, Pc_Write, If_Id_Write, rd);
    end
    step(0, 0, '0, '0, 0, '0, 0, 32'h3);
    total++;
    if (if_valid !== 1'b0 || Pc_Write !== 1'b0 || if_rdata !== rd || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL fetch_after valid=%b pcw=%b rdata=%h req=%b want 0/0/%h/0",
               if_valid, Pc_Write, if_rdata, mem_req, rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic [31:0] rd2;
    rd  = 32'h1234_5678;
    rd2 = 32'h0BAD_F00D;
    step(1, 1, 32'h200, 32'hDEAD_BEEF, 1, 32'h300, 0, '0);
    total++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200 ||
        mem_wdata !== 32'hDEAD_BEEF || Mem_Stall !== 1'b1) begin
      bad++;
      $display("FAIL b2b_data_grant req=%b we=%b addr=%h wdata=%h stall=%b want 1/1/200/deadbeef/1",
               mem_req, mem_we, mem_addr, mem_wdata, Mem_Stall);
    end
    step(1, 1, 32'h200, 32'hDEAD_BEEF, 1, 32'h300, 0, '0);
    total++;
    if (Mem_Stall !== 1'b1 || dm_done !== 1'b0) begin
      bad++;
      $display("FAIL b2b_stall stall=%b done=%b want 1/0", Mem_Stall, dm_done);
    end
    step(0, 0, '0, '0, 1, 32'h300, 1, rd);
    total++;
    if (dm_done !== 1'b1 || dm_rdata !== rd || mem_req !== 1'b1 ||
        mem_addr !== 32'h300 || mem_we !== 1'b0 || Mem_Stall !== 1'b0) begin
      bad++;
      $display("FAIL b2b_switch done=%b rdata=%h req=%b addr=%h we=%b stall=%b want 1/%h/1/300/0/0",
               dm_done, dm_rdata, mem_req, mem_addr, mem_we, Mem_Stall, rd);
    end
    step(0, 0, '0, '0, 0, '0, 1, rd2);
    total++;
    if (if_valid !== 1'b1 || if_rdata !== rd2 || dm_done !== 1'b0 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL b2b_fetch_done valid=%b rdata=%h done=%b req=%b want 1/%h/0/0",
               if_valid, if_rdata, dm_done, mem_req, rd2);
    end
  endtask

  task automatic test_starvation();
    string seq;
    string want;
    bit    prev_busy;
`ifdef STARVE_GUARD_EN
    want = "DDDFDD";
`else
    want = "DDDDDD";
`endif
    seq = "";
    prev_busy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 32'h400, 32'(i), 1, 32'h500, (i > 0), 32'(i));
      if (mem_req && ((i > 0) || !prev_busy))
        seq = {seq, (mem_addr == 32'h400) ? "D" : "F"};
      prev_busy = mem_req;
    end
    step(0, 0, '0, '0, 0, '0, 1, '0);
    total++;
    if (seq != want) begin
      bad++;
      $display("FAIL starve_sequence got=%s want=%s", seq, want);
    end
    total++;
    if (mem_req !== 1'b0) begin
      bad++;
      $display("FAIL starve_drain req=%b want 0", mem_req);
    end
  endtask

  task automatic test_reset_mid_data();
    step(1, 0, 32'h600, '0, 0, '0, 0, '0);
    step(1, 0, 32'h600, '0, 0, '0, 0, '0);
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    total++;
    if (mem_req !== 1'b0 || mem_addr !== '0) begin
      bad++;
      $display("FAIL rst_mid_async req=%b addr=%h want 0/0", mem_req, mem_addr);
    end
    @(posedge clk);
    #1;
    total++;
    if (dm_done !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_no_done done=%b want 0", dm_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dm_req = 1'b0;
    model_reset();
    step(0, 0, '0, '0, 0, '0, 1, 32'h77);
    total++;
    if (dm_done !== 1'b0 || mem_req !== 1'b0 || dm_rdata !== '0) begin
      bad++;
      $display("FAIL rst_mid_idle done=%b req=%b rdata=%h want 0/0/0", dm_done, mem_req, dm_rdata);
    end
  endtask

  task automatic test_drop_and_idle_ready();
    logic [31:0] rd;
    rd = 32'hCAFE_0700;
    step(0, 0, '0, '0, 1, 32'h700, 0, '0);
    step(0, 0, '0, '0, 0, 32'h700, 0, '0);
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h700) begin
      bad++;
      $display("FAIL drop_hold req=%b addr=%h want 1/700", mem_req, mem_addr);
    end
    step(0, 0, '0, '0, 0, '0, 1, rd);
    total++;
    if (if_valid !== 1'b1 || if_rdata !== rd) begin
      bad++;
      $display("FAIL drop_done valid=%b rdata=%h want 1/%h", if_valid, if_rdata, rd);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, '0, '0, 0, '0, 1, $urandom);
      total++;
      if (if_valid !== 1'b0 || dm_done !== 1'b0 || if_rdata !== rd || mem_req !== 1'b0) begin
        bad++;
        $display("FAIL idle_ready[%0d] valid=%b done=%b rdata=%h req=%b want 0/0/%h/0",
                 i, if_valid, dm_done, if_rdata, mem_req, rd);
      end
    end
  endtask

  task automatic test_random();
    bit          d;
    bit          we;
    bit          f;
    bit          rdy;
    logic [31:0] da;
    logic [31:0] dw;
    logic [31:0] fa;
    logic [31:0] rd;
    for (int n = 0; n < 400; n++) begin
      d   = ($urandom_range(0, 2) != 0);
      we  = $urandom_range(0, 1);
      f   = ($urandom_range(0, 3) != 0);
      rdy = $urandom_range(0, 1);
      da  = $urandom;
      dw  = $urandom;
      fa  = $urandom;
      rd  = $urandom;
      step(d, we, da, dw, f, fa, rdy, rd);
      total++;
      if (if_valid !== m_if_valid || dm_done !== m_dm_done || Pc_Write !== m_if_valid ||
          Mem_Stall !== (d && !m_dm_done)) begin
        bad++;
        $display("FAIL rnd_pulses[%0d] valid=%b done=%b pcw=%b stall=%b want %b/%b/%b/%b",
                 n, if_valid, dm_done, Pc_Write, Mem_Stall,
                 m_if_valid, m_dm_done, m_if_valid, d && !m_dm_done);
      end
      total++;
      if (if_rdata !== m_if_rdata || dm_rdata !== m_dm_rdata) begin
        bad++;
        $display("FAIL rnd_rdata[%0d] if=%h dm=%h want %h/%h",
                 n, if_rdata, dm_rdata, m_if_rdata, m_dm_rdata);
      end
      total++;
      if (mem_req !== m_busy) begin
        bad++;
        $display("FAIL rnd_req[%0d] req=%b want %b", n, mem_req, m_busy);
      end else if (m_busy) begin
        total++;
        if (mem_addr !== m_addr || mem_we !== m_we || (m_is_data && mem_wdata !== m_wdata)) begin
          bad++;
          $display("FAIL rnd_bus[%0d] addr=%h we=%b wdata=%h want %h/%b/%h",
                   n, mem_addr, mem_we, mem_wdata, m_addr, m_we, m_wdata);
        end
      end
    end
    step(0, 0, '0, '0, 0, '0, 1, '0);
    step(0, 0, '0, '0, 0, '0, 0, '0);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fetch();
    test_back_to_back();
    test_starvation();
    test_reset_mid_data();
    test_drop_and_idle_ready();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width of every address port.
REQ-002 Parameter: DATA_W, 32, data width of every data port.
REQ-003 Parameter: STARVE_MAX, 3, consecutive data grants allowed while fetch waits (STARVE_GUARD_EN only).
REQ-004 The block SHALL use one clock, and reset SHALL be asynchronous and active-low, with ports exactly as follows:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- if_req  input  1  fetch stage requests an instruction (level)
- if_addr  input  ADDR_W  fetch address (PC)
- if_valid  output  1  one-cycle pulse: if_rdata is valid
- if_rdata  output  DATA_W  fetched instruction
- dm_req  input  1  MEM stage requests a load or store (level)
- dm_we  input  1  1 = store, 0 = load
- dm_addr  input  ADDR_W  data address
- dm_wdata  input  DATA_W  store data
- dm_done  output  1  one-cycle pulse: data access complete; dm_rdata valid for loads
- dm_rdata  output  DATA_W  load data
- mem_req  output  1  request to the single-port memory
- mem_we  output  1  write enable to memory
- mem_addr  output  ADDR_W  registered memory address
- mem_wdata  output  DATA_W  registered write data
- mem_ready  input  1  memory completes the current access this cycle
- mem_rdata  input  DATA_W  memory read data, valid with mem_ready
- Pc_Write  output  1  0 = hold PC
- If_Id_Write  output  1  0 = hold IF/ID register
- Mem_Stall  output  1  1 = freeze EX/MEM and earlier stages

Function
REQ-005 The FSM SHALL have the states IDLE, FETCH and DATA.
REQ-006 Arbitration in IDLE: dm_req=1 -> DATA; else if_req=1 -> FETCH; else stay in IDLE. Without the guard, data always wins.
REQ-007 On a grant edge, mem_addr, mem_we and mem_wdata SHALL be registered from the winning requester; mem_we SHALL be 0 for fetch; mem_req SHALL be 1 from the next cycle.
REQ-008 mem_req, mem_addr, mem_we and mem_wdata SHALL hold stable in FETCH/DATA until a cycle with mem_ready=1.
REQ-009 mem_ready=1 in FETCH: if_rdata <= mem_rdata and if_valid pulses 1 on the following cycle. In DATA, dm_rdata/dm_done do the same.
REQ-010 On the completion edge, the next state SHALL be chosen with IDLE arbitration (REQ-006) so back-to-back accesses incur no idle cycle; mem_req stays 1 if a new grant occurs.
REQ-011 Minimum latency: request sampled -> mem_req 1 cycle -> done pulse 1 cycle after mem_ready.
REQ-012 Pc_Write = If_Id_Write = if_valid (combinational).
REQ-013 Mem_Stall = dm_req & ~dm_done (combinational).
REQ-014 If a requester deasserts mid-transaction, the access SHALL still complete and the done/valid pulse SHALL still be issued.
REQ-015 mem_ready in IDLE SHALL be ignored.
REQ-016 if_rdata and dm_rdata SHALL hold their last captured value between pulses.

Reset
REQ-017 rst_n=0 SHALL asynchronously force: state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_valid=0, dm_done=0, if_rdata=0, dm_rdata=0, starvation counter=0.
REQ-018 Reset during FETCH/DATA SHALL abandon the access with no done/valid pulse.

Configuration
REQ-019 Macro STARVE_GUARD_EN defined: a counter SHALL count consecutive data grants made while if_req=1.
- The counter SHALL clear on any fetch grant or when if_req=0.
- When the counter equals STARVE_MAX and if_req=1, the next grant SHALL go to fetch, even with dm_req=1.
REQ-020 Macro STARVE_GUARD_EN undefined: the counter SHALL be absent and strict data priority SHALL apply.

Verification
REQ-021 if_req=1, if_addr=0x100, mem_ready high 2 cycles after mem_req -> mem_addr=0x100, mem_we=0; if_valid pulses once with if_rdata=mem_rdata; Pc_Write=1 only in that cycle.
REQ-022 if_req=1 and dm_req=1 (store, 0x200, 0xDEADBEEF) in the same cycle -> DATA first with mem_we=1; then FETCH back-to-back with no IDLE cycle; Mem_Stall=1 until the dm_done cycle.
REQ-023 dm_req held 1 for 6 accesses with if_req=1, STARVE_GUARD_EN defined, STARVE_MAX=3 -> grant sequence D,D,D,F,D,D. Undefined -> D,D,D,D,D,D.
REQ-024 rst_n pulsed low while in DATA before mem_ready -> mem_req=0 immediately; no dm_done pulse; state IDLE.
REQ-025 if_req dropped one cycle after grant -> fetch completes; if_valid still pulses; mem_ready while idle -> no pulse.
